// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALUOp and control-bundle definitions
// for the 5-stage MIPS pipeline control.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam int EX_LINK_BIT   = 0;
    localparam int EX_REGDST_BIT = 1;
    localparam int EX_ALUOP_LSB  = 2;
    localparam int MEM_RD_BIT    = 1;
    localparam int MEM_WR_BIT    = 0;
    localparam int WB_REGWR_BIT  = 1;
    localparam int WB_M2R_BIT    = 0;

    typedef struct packed {
        logic       alu_src;
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       link;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage opcode decoder: control bundle,
// instruction class flags and illegal-opcode detection.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op_i,
    output ctrl_t           ctrl_o,
    output logic            illegal_o,
    output logic            branch_o,
    output logic            bne_o,
    output logic            jump_o,
    output logic            uses_rt_o
);

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        branch_o  = 1'b0;
        bne_o     = 1'b0;
        jump_o    = 1'b0;
        uses_rt_o = 1'b0;
        case (op_i)
            OP_W'(OP_RTYPE): begin
                ctrl_o.alu_op    = ALU_FUNCT;
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                uses_rt_o        = 1'b1;
            end
            OP_W'(OP_ADDI): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.reg_write = 1'b1;
            end
            OP_W'(OP_ANDI): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_AND;
                ctrl_o.reg_write = 1'b1;
            end
            OP_W'(OP_ORI): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_OR;
                ctrl_o.reg_write = 1'b1;
            end
            OP_W'(OP_SLTI): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_SLT;
                ctrl_o.reg_write = 1'b1;
            end
            OP_W'(OP_LW): begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            OP_W'(OP_SW): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.mem_write = 1'b1;
                uses_rt_o        = 1'b1;
            end
            OP_W'(OP_BEQ): begin
                ctrl_o.alu_op = ALU_SUB;
                branch_o      = 1'b1;
                uses_rt_o     = 1'b1;
            end
            OP_W'(OP_BNE): begin
                ctrl_o.alu_op = ALU_SUB;
                branch_o      = 1'b1;
                bne_o         = 1'b1;
                uses_rt_o     = 1'b1;
            end
            OP_W'(OP_J): begin
                jump_o = 1'b1;
            end
            OP_W'(OP_JAL): begin
                ctrl_o.link      = 1'b1;
                ctrl_o.reg_write = 1'b1;
                jump_o           = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline main control: decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use stall, flush bubbles, freeze, stall counter.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               valid_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [REG_W-1:0]   rs_i,
    input  logic [REG_W-1:0]   rt_i,
    input  logic               flush_i,
    input  logic               freeze_i,
    output logic               jump_o,
    output logic               branch_o,
    output logic               branch_ne_o,
    output logic               hazard_stall_o,
    output logic [ALUOP_W+2:0] ex_ctrl_o,
    output logic [1:0]         mem_ctrl_o,
    output logic [1:0]         wb_ctrl_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    ctrl_t dec;
    logic  dec_ill, dec_br, dec_bne, dec_jmp, dec_use_rt;
    logic  live, hz_cond, go;

    logic [ALUOP_W+2:0] idex_ex_q, idex_ex_d;
    logic [1:0]         idex_mem_q, idex_mem_d;
    logic [1:0]         idex_wb_q, idex_wb_d;
    logic [REG_W-1:0]   idex_rt_q, idex_rt_d;
    logic               ill_q, ill_d;
    logic [1:0]         exmem_mem_q, exmem_mem_d;
    logic [1:0]         exmem_wb_q, exmem_wb_d;
    logic [1:0]         memwb_wb_q, memwb_wb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    ctrl_decode #(.OP_W(OP_W)) u_dec (
        .op_i      (op_i),
        .ctrl_o    (dec),
        .illegal_o (dec_ill),
        .branch_o  (dec_br),
        .bne_o     (dec_bne),
        .jump_o    (dec_jmp),
        .uses_rt_o (dec_use_rt)
    );

    always_comb begin
        hz_cond = idex_mem_q[MEM_RD_BIT] && (idex_rt_q != '0)
                  && ((idex_rt_q == rs_i)
                      || ((idex_rt_q == rt_i) && dec_use_rt));
        live           = valid_i && !flush_i;
        hazard_stall_o = live && hz_cond;
        go             = live && !hazard_stall_o;
        jump_o         = go && dec_jmp;
        branch_o       = go && dec_br;
        branch_ne_o    = go && dec_bne;
    end

    always_comb begin
        idex_ex_d   = idex_ex_q;
        idex_mem_d  = idex_mem_q;
        idex_wb_d   = idex_wb_q;
        idex_rt_d   = idex_rt_q;
        ill_d       = ill_q;
        exmem_mem_d = exmem_mem_q;
        exmem_wb_d  = exmem_wb_q;
        memwb_wb_d  = memwb_wb_q;
        cnt_d       = cnt_q;
        if (!freeze_i) begin
            // Bubble by default; an illegal opcode decodes to a zero bundle
            idex_ex_d  = '0;
            idex_mem_d = '0;
            idex_wb_d  = '0;
            idex_rt_d  = '0;
            ill_d      = 1'b0;
            if (go) begin
                idex_ex_d  = {dec.alu_src, ALUOP_W'(dec.alu_op),
                              dec.reg_dst, dec.link};
                idex_mem_d = {dec.mem_read, dec.mem_write};
                idex_wb_d  = {dec.reg_write, dec.mem_to_reg};
                idex_rt_d  = rt_i;
                ill_d      = dec_ill;
            end
            exmem_mem_d = idex_mem_q;
            exmem_wb_d  = idex_wb_q;
            memwb_wb_d  = exmem_wb_q;
            if (hazard_stall_o && (cnt_q != '1))
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idex_ex_q   <= '0;
            idex_mem_q  <= '0;
            idex_wb_q   <= '0;
            idex_rt_q   <= '0;
            ill_q       <= 1'b0;
            exmem_mem_q <= '0;
            exmem_wb_q  <= '0;
            memwb_wb_q  <= '0;
            cnt_q       <= '0;
        end else begin
            idex_ex_q   <= idex_ex_d;
            idex_mem_q  <= idex_mem_d;
            idex_wb_q   <= idex_wb_d;
            idex_rt_q   <= idex_rt_d;
            ill_q       <= ill_d;
            exmem_mem_q <= exmem_mem_d;
            exmem_wb_q  <= exmem_wb_d;
            memwb_wb_q  <= memwb_wb_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_ctrl_o   = idex_ex_q;
    assign mem_ctrl_o  = exmem_mem_q;
    assign wb_ctrl_o   = memwb_wb_q;
    assign illegal_o   = ill_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit; a second instance with a
// 2-bit counter shares the stimulus to exercise saturation.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, flush, freeze;
    logic [5:0] op;
    logic [4:0] rs, rt;

    logic        jump, branch, branch_ne, stall, ill;
    logic [5:0]  ex;
    logic [1:0]  mem, wb;
    logic [15:0] cnt;

    logic        jump2, branch2, branch_ne2, stall2, ill2;
    logic [5:0]  ex2;
    logic [1:0]  mem2, wb2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] RT = 6'h00, ADDI = 6'h08, ANDI = 6'h0C;
    localparam logic [5:0] ORI = 6'h0D, SLTI = 6'h0A, LW = 6'h23;
    localparam logic [5:0] SW = 6'h2B, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [5:0] J = 6'h02, JAL = 6'h03, BAD = 6'h3F;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.OP_W(6), .REG_W(5), .ALUOP_W(3), .CNT_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .op_i(op),
        .rs_i(rs), .rt_i(rt), .flush_i(flush), .freeze_i(freeze),
        .jump_o(jump), .branch_o(branch), .branch_ne_o(branch_ne),
        .hazard_stall_o(stall), .ex_ctrl_o(ex), .mem_ctrl_o(mem),
        .wb_ctrl_o(wb), .illegal_o(ill), .stall_cnt_o(cnt)
    );

    pipe_ctrl_unit #(.OP_W(6), .REG_W(5), .ALUOP_W(3), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .op_i(op),
        .rs_i(rs), .rt_i(rt), .flush_i(flush), .freeze_i(freeze),
        .jump_o(jump2), .branch_o(branch2), .branch_ne_o(branch_ne2),
        .hazard_stall_o(stall2), .ex_ctrl_o(ex2), .mem_ctrl_o(mem2),
        .wb_ctrl_o(wb2), .illegal_o(ill2), .stall_cnt_o(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] o,
                         input logic [4:0] s, input logic [4:0] t,
                         input logic fl, input logic fz);
        valid  = v;
        op     = o;
        rs     = s;
        rt     = t;
        flush  = fl;
        freeze = fz;
        #1;
    endtask

    task automatic regs(input string tag, input logic [5:0] e,
                        input logic [1:0] m, input logic [1:0] w);
        chk({tag, ".ex"}, 32'(ex), 32'(e));
        chk({tag, ".mem"}, 32'(mem), 32'(m));
        chk({tag, ".wb"}, 32'(wb), 32'(w));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, RT, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        regs("rst", 6'h00, 2'b00, 2'b00);
        chk("rst.cnt", 32'(cnt), 0);
        chk("rst.ill", 32'(ill), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        regs("rel", 6'h00, 2'b00, 2'b00);

        // back-to-back lw, R, sw, then andi/ori/slti
        drive(1, LW, 2, 1, 0, 0);
        tick();
        regs("s1", 6'h20, 2'b00, 2'b00);
        drive(1, RT, 3, 4, 0, 0);
        chk("s1.nostall", 32'(stall), 0);
        tick();
        regs("s2", 6'h0A, 2'b10, 2'b00);
        drive(1, SW, 3, 4, 0, 0);
        tick();
        regs("s3", 6'h20, 2'b00, 2'b11);
        drive(1, ANDI, 0, 1, 0, 0);
        tick();
        regs("s4", 6'h2C, 2'b01, 2'b10);
        drive(1, ORI, 0, 1, 0, 0);
        tick();
        regs("s5", 6'h30, 2'b00, 2'b00);
        drive(1, SLTI, 0, 1, 0, 0);
        tick();
        chk("slti.ex", 32'(ex), 32'h34);
        drive(0, RT, 0, 0, 0, 0);
        tick();
        chk("cnt0", 32'(cnt), 0);

        // load-use on rs
        drive(1, LW, 0, 5, 0, 0);
        tick();
        drive(1, RT, 5, 6, 0, 0);
        chk("lu.stall", 32'(stall), 1);
        tick();
        regs("lu.bub", 6'h00, 2'b10, 2'b00);
        chk("lu.cnt", 32'(cnt), 1);
        chk("lu.release", 32'(stall), 0);
        tick();
        chk("lu.ex", 32'(ex), 32'h0A);
        // rt=0 never stalls
        drive(1, LW, 0, 0, 0, 0);
        tick();
        drive(1, RT, 0, 0, 0, 0);
        chk("r0.stall", 32'(stall), 0);
        tick();
        chk("r0.ex", 32'(ex), 32'h0A);
        chk("r0.cnt", 32'(cnt), 1);

        // load-use on a branch's rt
        drive(1, LW, 0, 7, 0, 0);
        tick();
        drive(1, BEQ, 1, 7, 0, 0);
        chk("beq.stall", 32'(stall), 1);
        chk("beq.br_hold", 32'(branch), 0);
        tick();
        chk("beq.br", 32'(branch), 1);
        chk("beq.ne", 32'(branch_ne), 0);
        chk("beq.cnt", 32'(cnt), 2);
        chk("beq.cnt2", 32'(cnt2), 2);
        drive(1, LW, 0, 7, 0, 0);
        tick();
        drive(1, BNE, 1, 7, 0, 0);
        chk("bne.stall", 32'(stall), 1);
        chk("bne.ne_hold", 32'(branch_ne), 0);
        tick();
        chk("bne.ne", 32'(branch_ne), 1);
        tick();
        chk("bne.ex", 32'(ex), 32'h04);
        chk("bne.cnt", 32'(cnt), 3);

        // flush, flush vs hazard, jumps
        drive(1, ADDI, 0, 1, 1, 0);
        tick();
        chk("fl.ex", 32'(ex), 0);
        drive(1, LW, 0, 9, 0, 0);
        tick();
        drive(1, RT, 9, 1, 1, 0);
        chk("flhz.stall", 32'(stall), 0);
        tick();
        chk("flhz.ex", 32'(ex), 0);
        chk("flhz.cnt", 32'(cnt), 3);
        drive(1, J, 0, 0, 0, 0);
        chk("j.jump", 32'(jump), 1);
        tick();
        chk("j.ex", 32'(ex), 0);
        drive(1, JAL, 0, 0, 0, 0);
        chk("jal.jump", 32'(jump), 1);
        tick();
        chk("jal.ex", 32'(ex), 32'h01);
        drive(0, RT, 0, 0, 0, 0);
        chk("nv.jump", 32'(jump), 0);
        tick();
        tick();
        chk("jal.wb", 32'(wb), 32'h2);

        // freeze with a pending hazard
        tick();
        tick();
        drive(1, ADDI, 0, 1, 0, 0);
        tick();
        drive(1, SW, 0, 1, 0, 0);
        tick();
        drive(1, LW, 0, 2, 0, 0);
        tick();
        regs("fz.pre", 6'h20, 2'b01, 2'b10);
        drive(1, RT, 2, 3, 0, 1);
        chk("fz.stall", 32'(stall), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            regs("fz.hold", 6'h20, 2'b01, 2'b10);
            chk("fz.cnt", 32'(cnt), 3);
        end
        drive(1, RT, 2, 3, 0, 0);
        tick();
        regs("fz.post", 6'h00, 2'b10, 2'b00);
        chk("fz.cnt4", 32'(cnt), 4);
        tick();
        chk("fz.rex", 32'(ex), 32'h0A);

        // illegal opcode
        drive(1, BAD, 0, 0, 0, 0);
        tick();
        chk("ill.flag", 32'(ill), 1);
        chk("ill.ex", 32'(ex), 0);
        drive(0, RT, 0, 0, 0, 0);
        tick();
        chk("ill.clr", 32'(ill), 0);
        chk("ill.mem", 32'(mem), 0);

        // five consecutive load-use hazards
        for (int i = 0; i < 5; i++) begin
            drive(1, LW, 0, 5, 0, 0);
            tick();
            drive(1, RT, 5, 6, 0, 0);
            chk("sat.stall", 32'(stall), 1);
            tick();
            tick();
        end
        chk("sat.cnt", 32'(cnt), 9);
        chk("sat.cnt2", 32'(cnt2), 3);

        // asynchronous reset mid-stream
        drive(1, LW, 0, 4, 0, 0);
        tick();
        chk("ar.pre", 32'(ex), 32'h20);
        rst_n = 1'b0;
        #1;
        regs("ar", 6'h00, 2'b00, 2'b00);
        chk("ar.cnt", 32'(cnt), 0);
        chk("ar.cnt2", 32'(cnt2), 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, RT, 0, 0, 0, 0);
        tick();
        regs("ar.rel", 6'h00, 2'b00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
